// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result demultiplexer.
// Data width, channel indices, result type and run-state enum.
package alu_pkg;

    localparam int ALU_WIDTH = 4;

    // Destination channel indices carried by in_sel
    localparam logic CH_REG  = 1'b0;
    localparam logic CH_FLAG = 1'b1;

    typedef logic [ALU_WIDTH-1:0] alu_res_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } run_state_e;

endpackage

// File: rtl/alu_res_slot.sv
// One-entry output slot with valid/ready and a saturating beat counter.
// Ports: clk, rst_n, load/din (fill), ready/valid/data (drain), clr, cnt.
module alu_res_slot #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             clr,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] cnt
);

    // load is only raised when the slot is empty or draining this
    // cycle, so a load never overwrites data the consumer has not taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    // clr wins over a same-edge increment; saturate instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_result_demux.sv
// Registered 1-to-2 demux steering ALU results to two handshaked slots.
// Ports: in_* upstream beat, out0_*/out1_* channels, clr, cnt0/cnt1.
module alu_result_demux
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    run_state_e state;
    logic       sel_free;
    logic       accept;
    logic       load0;
    logic       load1;

    // One idle cycle after reset before any beat can be taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
        end else begin
            unique case (state)
                INIT: state <= RUN;
                RUN:  state <= RUN;
                default: state <= INIT;
            endcase
        end
    end

    // A slot can take a beat if empty or being drained on this edge
    always_comb begin
        if (in_sel == CH_REG) begin
            sel_free = ~out0_valid | out0_ready;
        end else begin
            sel_free = ~out1_valid | out1_ready;
        end
    end

    assign in_ready = (state == RUN) & sel_free;
    assign accept   = in_valid & in_ready;
    assign load0    = accept & (in_sel == CH_REG);
    assign load1    = accept & (in_sel == CH_FLAG);

    alu_res_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot0 (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load0),
        .din   (in_data),
        .clr   (clr),
        .ready (out0_ready),
        .valid (out0_valid),
        .data  (out0_data),
        .cnt   (cnt0)
    );

    alu_res_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot1 (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load1),
        .din   (in_data),
        .clr   (clr),
        .ready (out1_ready),
        .valid (out1_valid),
        .data  (out1_data),
        .cnt   (cnt1)
    );

endmodule

// File: tb/tb_alu_result_demux.sv
// Self-checking bench for alu_result_demux (table vectors + scoreboard).
// A second instance with 2-bit counters exercises saturation.
module tb_alu_result_demux;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_sel;
    logic       out0_valid;
    logic       out0_ready;
    logic [3:0] out0_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [3:0] out1_data;
    logic       clr;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    logic       s_in_ready;
    logic       s_out0_valid;
    logic [3:0] s_out0_data;
    logic       s_out1_valid;
    logic [3:0] s_out1_data;
    logic [1:0] s_cnt0;
    logic [1:0] s_cnt1;

    int checks = 0;
    int errors = 0;

    logic [3:0] q0[$];
    logic [3:0] q1[$];

    alu_result_demux #(.WIDTH(4), .CNT_W(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .clr        (clr),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    alu_result_demux #(.WIDTH(4), .CNT_W(2)) u_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (s_in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (s_out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (s_out0_data),
        .out1_valid (s_out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (s_out1_data),
        .clr        (clr),
        .cnt0       (s_cnt0),
        .cnt1       (s_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic       sel;
        logic [3:0] d;
        logic       r0;
        logic       r1;
        logic       cl;
        logic       rdy;
        logic       v0;
        logic [3:0] d0;
        logic       v1;
        logic [3:0] d1;
        int         c0;
        int         c1;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(
        input logic iv, input logic sel, input logic [3:0] d,
        input logic r0, input logic r1, input logic cl,
        input logic rdy,
        input logic v0, input logic [3:0] d0,
        input logic v1, input logic [3:0] d1,
        input int c0, input int c1
    );
        vec_t v;
        v.iv = iv; v.sel = sel; v.d = d;
        v.r0 = r0; v.r1 = r1; v.cl = cl;
        v.rdy = rdy;
        v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
        v.c0 = c0; v.c1 = c1;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle: check in_ready, score drains, track accepts, clock.
    task automatic cycle(
        input logic iv, input logic sel, input logic [3:0] d,
        input logic r0, input logic r1, input logic cl,
        input logic exp_rdy
    );
        in_valid = iv; in_sel = sel; in_data = d;
        out0_ready = r0; out1_ready = r1; clr = cl;
        #1;
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        if (out0_valid && out0_ready) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL drain0: got %0d expected none", out0_data);
            end else begin
                logic [3:0] e;
                e = q0.pop_front();
                if (out0_data != e) begin
                    errors++;
                    $display("FAIL drain0: got %0d expected %0d", out0_data, e);
                end
            end
        end
        if (out1_valid && out1_ready) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL drain1: got %0d expected none", out1_data);
            end else begin
                logic [3:0] e;
                e = q1.pop_front();
                if (out1_data != e) begin
                    errors++;
                    $display("FAIL drain1: got %0d expected %0d", out1_data, e);
                end
            end
        end
        if (iv && exp_rdy) begin
            if (sel) q1.push_back(d);
            else     q0.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // iv sel d  r0 r1 clr | rdy | v0 d0 v1 d1 c0 c1
        tbl[0]  = mk(1, 0, 4'h3, 1, 1, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0);
        tbl[1]  = mk(0, 0, 4'h0, 1, 1, 0, 1, 0, 4'h0, 0, 4'h0, 0, 0);
        tbl[2]  = mk(1, 0, 4'hA, 1, 1, 0, 1, 1, 4'hA, 0, 4'h0, 1, 0);
        tbl[3]  = mk(1, 1, 4'h1, 1, 1, 0, 1, 0, 4'hA, 1, 4'h1, 1, 1);
        tbl[4]  = mk(1, 1, 4'h2, 1, 1, 0, 1, 0, 4'hA, 1, 4'h2, 1, 2);
        tbl[5]  = mk(1, 1, 4'h3, 1, 1, 0, 1, 0, 4'hA, 1, 4'h3, 1, 3);
        tbl[6]  = mk(1, 1, 4'h4, 1, 1, 0, 1, 0, 4'hA, 1, 4'h4, 1, 4);
        tbl[7]  = mk(1, 0, 4'h5, 0, 1, 0, 1, 1, 4'h5, 0, 4'h4, 2, 4);
        tbl[8]  = mk(1, 0, 4'h6, 0, 1, 0, 0, 1, 4'h5, 0, 4'h4, 2, 4);
        tbl[9]  = mk(1, 1, 4'h9, 0, 1, 0, 1, 1, 4'h5, 1, 4'h9, 2, 5);
        tbl[10] = mk(1, 1, 4'h7, 0, 1, 0, 1, 1, 4'h5, 1, 4'h7, 2, 6);
        tbl[11] = mk(0, 0, 4'h0, 1, 1, 0, 1, 0, 4'h5, 0, 4'h7, 2, 6);
        tbl[12] = mk(1, 0, 4'h8, 1, 1, 1, 1, 1, 4'h8, 0, 4'h7, 0, 0);
        tbl[13] = mk(0, 0, 4'h0, 1, 1, 0, 1, 0, 4'h8, 0, 4'h7, 0, 0);

        rst_n = 1'b0;
        in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out0_ready = 1'b0; out1_ready = 1'b0; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_v0", int'(out0_valid), 0);
        chk("rst_v1", int'(out1_valid), 0);
        chk("rst_d0", int'(out0_data), 0);
        chk("rst_d1", int'(out1_data), 0);
        chk("rst_cnt0", int'(cnt0), 0);
        chk("rst_cnt1", int'(cnt1), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].iv, tbl[i].sel, tbl[i].d,
                  tbl[i].r0, tbl[i].r1, tbl[i].cl, tbl[i].rdy);
            chk($sformatf("v0[%0d]", i), int'(out0_valid), int'(tbl[i].v0));
            chk($sformatf("d0[%0d]", i), int'(out0_data), int'(tbl[i].d0));
            chk($sformatf("v1[%0d]", i), int'(out1_valid), int'(tbl[i].v1));
            chk($sformatf("d1[%0d]", i), int'(out1_data), int'(tbl[i].d1));
            chk($sformatf("c0[%0d]", i), int'(cnt0), tbl[i].c0);
            chk($sformatf("c1[%0d]", i), int'(cnt1), tbl[i].c1);
            chk($sformatf("sc0[%0d]", i), int'(s_cnt0),
                tbl[i].c0 > 3 ? 3 : tbl[i].c0);
            chk($sformatf("sc1[%0d]", i), int'(s_cnt1),
                tbl[i].c1 > 3 ? 3 : tbl[i].c1);
        end
        chk("q0_left", q0.size(), 0);
        chk("q1_left", q1.size(), 0);

        // Five beats into channel 0: narrow counter pins at 3
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 4'(i + 1), 1, 1, 0, 1);
        end
        cycle(0, 0, 4'h0, 1, 1, 0, 1);
        chk("sat_cnt0_w8", int'(cnt0), 5);
        chk("sat_cnt0_w2", int'(s_cnt0), 3);

        // 260 beats into channel 1: wide counter pins at 255
        for (int i = 0; i < 260; i++) begin
            cycle(1, 1, 4'(i), 1, 1, 0, 1);
        end
        cycle(0, 0, 4'h0, 1, 1, 0, 1);
        chk("sat_cnt1_w8", int'(cnt1), 255);
        chk("sat_cnt1_w2", int'(s_cnt1), 3);

        // clr with a same-cycle accept: that beat is not counted
        cycle(1, 0, 4'h2, 1, 1, 1, 1);
        chk("clr_cnt0", int'(cnt0), 0);
        chk("clr_cnt1", int'(cnt1), 0);
        chk("clr_scnt0", int'(s_cnt0), 0);
        chk("clr_v0", int'(out0_valid), 1);
        chk("clr_d0", int'(out0_data), 2);
        cycle(0, 0, 4'h0, 1, 1, 0, 1);
        chk("q0_left2", q0.size(), 0);
        chk("q1_left2", q1.size(), 0);

        // Fill both slots with stalled consumers, then reset between edges
        cycle(1, 0, 4'h5, 0, 0, 0, 1);
        cycle(1, 1, 4'h9, 0, 0, 0, 1);
        chk("pre_v0", int'(out0_valid), 1);
        chk("pre_v1", int'(out1_valid), 1);
        chk("pre_d1", int'(out1_data), 9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_v0", int'(out0_valid), 0);
        chk("mid_v1", int'(out1_valid), 0);
        chk("mid_rdy", int'(in_ready), 0);
        chk("mid_cnt0", int'(cnt0), 0);
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, 0, 4'h3, 1, 1, 0, 0);
        chk("init_v0", int'(out0_valid), 0);
        chk("init_cnt0", int'(cnt0), 0);
        cycle(1, 0, 4'h3, 1, 1, 0, 1);
        chk("run_v0", int'(out0_valid), 1);
        chk("run_d0", int'(out0_data), 3);
        chk("run_cnt0", int'(cnt0), 1);
        cycle(0, 0, 4'h0, 1, 1, 0, 1);
        chk("q0_left3", q0.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
